// File: rtl/lsu_initiator.sv
`default_nettype none
// ============================================================================
// lsu_initiator : load/store initiator between execute stage and data RAM
// Rev 1.0
// ============================================================================
module lsu_initiator #(
  parameter int ADDR_WIDTH   = 12,
  parameter bit CHECK_BOUNDS = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_illegal,
  output logic        rsp_fault,
  output logic [31:0] rsp_addr,
  output logic        mem_load,
  output logic        mem_store,
  output logic [2:0]  mem_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_issue   = 2'd1;
  localparam logic [1:0] c_st_capture = 2'd2;
  localparam logic [1:0] c_st_resp    = 2'd3;
  localparam logic [2:0] c_acc_word   = 3'b010;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [31:0] r_eff;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_is_load;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_rsp_addr;
  logic        r_rsp_mis;
  logic        r_rsp_ill;
  logic        r_rsp_flt;

  logic [31:0] w_eff;
  logic        w_accept;
  logic        w_ill;
  logic        w_mis_raw;
  logic        w_oob;
  logic        w_err;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_eff     = req_base + req_offset;
  assign req_ready = (r_state == c_st_idle) && rstn;
  assign w_accept  = req_valid && req_ready;

  assign w_ill = (req_load == req_store) || (req_funct3 == 3'b011) ||
                 (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                 (req_store && req_funct3[2]);
  assign w_mis_raw = ((req_funct3[1:0] == 2'b01) && w_eff[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (w_eff[1:0] != 2'b00));

  generate
    if (CHECK_BOUNDS && (ADDR_WIDTH < 32)) begin : g_bounds
      assign w_oob = |w_eff[31:ADDR_WIDTH];
    end else begin : g_no_bounds
      assign w_oob = 1'b0;
    end
  endgenerate

  assign w_err = w_ill || w_mis_raw || w_oob;

  // RAM returns the whole aligned word; pick the lane addressed by the request
  assign w_shifted = mem_rdata >> {r_eff[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_eff[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ext = mem_rdata;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= c_st_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:    if (w_accept) w_next = w_err ? c_st_resp : c_st_issue;
      c_st_issue:   w_next = r_is_load ? c_st_capture : c_st_resp;
      c_st_capture: w_next = c_st_resp;
      default:      w_next = c_st_idle;
    endcase
  end

  // Response registers change only when entering RESP, so they hold between responses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_eff       <= 32'd0;
      r_wdata     <= 32'd0;
      r_funct3    <= 3'd0;
      r_is_load   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_addr  <= 32'd0;
      r_rsp_mis   <= 1'b0;
      r_rsp_ill   <= 1'b0;
      r_rsp_flt   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_eff     <= w_eff;
        r_wdata   <= req_wdata;
        r_funct3  <= req_funct3;
        r_is_load <= req_load;
      end
      if (w_accept && w_err) begin
        r_rsp_rdata <= 32'd0;
        r_rsp_addr  <= w_eff;
        r_rsp_ill   <= w_ill;
        r_rsp_mis   <= !w_ill && w_mis_raw;
        r_rsp_flt   <= !w_ill && !w_mis_raw && w_oob;
      end
      if ((r_state == c_st_issue) && !r_is_load) begin
        r_rsp_rdata <= 32'd0;
        r_rsp_addr  <= r_eff;
        r_rsp_ill   <= 1'b0;
        r_rsp_mis   <= 1'b0;
        r_rsp_flt   <= 1'b0;
      end
      if (r_state == c_st_capture) begin
        r_rsp_rdata <= w_ext;
        r_rsp_addr  <= r_eff;
        r_rsp_ill   <= 1'b0;
        r_rsp_mis   <= 1'b0;
        r_rsp_flt   <= 1'b0;
      end
    end
  end

  always_comb begin
    rsp_valid  = (r_state == c_st_resp);
    mem_load   = 1'b0;
    mem_store  = 1'b0;
    mem_access = 3'd0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    if (r_state == c_st_issue) begin
      if (r_is_load) begin
        mem_load   = 1'b1;
        mem_access = c_acc_word;
        mem_addr   = {r_eff[31:2], 2'b00};
      end else begin
        mem_store  = 1'b1;
        mem_access = r_funct3;
        mem_addr   = r_eff;
        mem_wdata  = r_wdata;
      end
    end
  end

  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_addr       = r_rsp_addr;
  assign rsp_misaligned = r_rsp_mis;
  assign rsp_illegal    = r_rsp_ill;
  assign rsp_fault      = r_rsp_flt;

endmodule
`default_nettype wire

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
Load/store initiator between the simplerv execute stage and the byte-addressed data RAM. It accepts one memory request at a time, computes the effective address, and checks alignment, funct3 legality and address range. It drives the RAM's load/store/access/addr/data_in strobes, captures the RAM's registered read data, performs byte/halfword extraction and extension, and returns a single-cycle response pulse.

Parameters:
ADDR_WIDTH, 12, implemented RAM address bits; bytes 0 .. 2^ADDR_WIDTH-1 are valid.
CHECK_BOUNDS, 1, when 1, eff_addr[31:ADDR_WIDTH] != 0 raises rsp_fault; when 0, no range check.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high when a request can be accepted
req_load  in  1  request is a load
req_store  in  1  request is a store
req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_base  in  32  rs1 value
req_offset  in  32  sign-extended immediate
req_wdata  in  32  rs2 value for stores
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_misaligned  out  1  H/HU with addr[0]=1, or W with addr[1:0]!=0
rsp_illegal  out  1  bad funct3 or bad load/store combination
rsp_fault  out  1  out-of-range address (CHECK_BOUNDS=1 only)
rsp_addr  out  32  effective address of the responded request
mem_load  out  1  RAM read strobe
mem_store  out  1  RAM write strobe
mem_access  out  3  RAM access code, same encoding as funct3
mem_addr  out  32  RAM byte address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data; registered, valid the cycle after mem_load

Behaviour:
- Reset: rstn sampled on posedge clk only.
- On reset: state=IDLE; all rsp_* and mem_* outputs = 0; req_ready=0 while rstn=0.
- Reset mid-operation: transaction abandoned on that edge, no response issued, mem strobes drop.
- req_ready = (state==IDLE) && rstn. Accept = req_valid && req_ready.
- Effective address: eff = req_base + req_offset, mod 2^32. Latched on accept together with funct3, kind and wdata.
- Error priority at accept: illegal > misaligned > fault.
  - Illegal: req_load==req_store, funct3 in {011,110,111}, or store with funct3[2]=1.
- States:
  - IDLE: on accept, go to RESP if any error, else go to ISSUE.
  - ISSUE (1 cycle):
    - Load: mem_load=1, mem_access=010, mem_addr={eff[31:2],2'b00}.
    - Store: mem_store=1, mem_access=funct3, mem_addr=eff, mem_wdata=req_wdata unshifted (RAM writes the low bytes at eff).
    - Next state: load -> CAPTURE; store -> RESP.
  - CAPTURE (1 cycle): mem_rdata is valid. Register the extracted result using lane=eff[1:0]:
    - B: sext(word[8*lane+7:8*lane])
    - BU: zext(word[8*lane+7:8*lane])
    - H: sext(word[16*eff[1]+15:16*eff[1]])
    - HU: zext(word[16*eff[1]+15:16*eff[1]])
    - W: word
  - RESP (1 cycle): rsp_valid=1 with rsp_rdata, error flags and rsp_addr=eff. Next state: IDLE.
- Outside their state, mem_load and mem_store are 0. rsp_valid is 0 outside RESP; other rsp_* hold their last values.
- Latency from accept edge to rsp_valid: load 3 cycles, store 2 cycles, error 1 cycle. No response backpressure.
- On an error, no mem strobe is ever asserted.
- The next request can be accepted in the cycle after RESP; throughput is one request per 2–4 cycles.

Test Plan:
- Store SW base=0x100, off=0x4, wdata=0xDEADBEEF -> one cycle with mem_store=1, mem_access=010, mem_addr=0x104. rsp_valid 2 cycles after accept with no error flags.
- Then LB base=0x104, off=3 -> mem_load pulse with mem_addr=0x104. rsp_rdata=0xFFFFFFDE 3 cycles after accept. LBU at the same address -> 0x000000DE.
- LH eff=0x106 on word 0xDEADBEEF -> rsp_rdata=0xFFFFDEAD. LHU eff=0x104 -> 0x0000BEEF.
- LW eff=0x102 -> rsp_misaligned=1 one cycle after accept, no mem_load, rsp_rdata=0. SB funct3=100 -> rsp_illegal=1.
- CHECK_BOUNDS=1, LW eff=0x1000 -> rsp_fault=1 with no strobe. Offset wrap: base=0xFFFFFFFC, off=0x104 gives eff=0x100 and a normal access.
- Assert rstn=0 during CAPTURE -> no rsp_valid; req_ready=1 in the first cycle after rstn=1; a new load completes correctly.
